// File: rtl/column_drop_if.sv
// Handshake and board bus between the column decoder / display stage and
// the column drop engine.
interface column_drop_if;
  logic        drop_valid;
  logic [1:0]  column_decode;
  logic [31:0] board;
  logic [1:0]  current_player;
  logic        drop_ok;
  logic        drop_err;
  logic        busy;
  logic        game_over;
  logic [1:0]  winner;

  modport master (
    output drop_valid, column_decode,
    input  board, current_player, drop_ok, drop_err, busy, game_over, winner
  );

  modport slave (
    input  drop_valid, column_decode,
    output board, current_player, drop_ok, drop_err, busy, game_over, winner
  );
endinterface

// File: rtl/column_drop_engine.sv
// Column drop engine for a 4x4 connect-four style board.
// Drops the current player's piece into the lowest empty cell of the
// requested column, then checks for a win or a draw and alternates turns.
//
// state | meaning
// IDLE  | waiting for a drop request; column is latched on acceptance
// PLACE | write piece into latched column, or reject if the column is full
// CHECK | evaluate the updated board for win / draw, report drop_ok
// OVER  | game finished; every request is rejected until reset
module column_drop_engine (
  input  logic         clk,
  input  logic         reset,
  column_drop_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PLACE, CHECK, OVER} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [31:0]     board_q;
  logic [1:0]      player_q;
  logic [1:0]      winner_q;
  logic [1:0]      col_q;
  logic            ok_q;
  logic            err_q;
  logic [3:0][2:0] h;
  logic [4:0]      move_cnt;
  logic [2:0]      h_sel;
  logic            col_full;
  logic [3:0]      wr_cell;
  logic            line_win;
  logic [1:0]      cells [4][4];

  function automatic logic same4(input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] c, input logic [1:0] d);
    return (a != 2'b00) && (a == b) && (a == c) && (a == d);
  endfunction

  // Row/column view of the packed board, row 0 at the bottom.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign cells[r][c] = board_q[(r*4+c)*2 +: 2];
    end
  end

  assign h_sel    = h[col_q];
  assign col_full = (h_sel == 3'd4);
  assign wr_cell  = {h_sel[1:0], col_q};

  // Any of the 4 rows, 4 columns or 2 diagonals completed by one player.
  assign line_win =
      same4(cells[0][0], cells[0][1], cells[0][2], cells[0][3]) |
      same4(cells[1][0], cells[1][1], cells[1][2], cells[1][3]) |
      same4(cells[2][0], cells[2][1], cells[2][2], cells[2][3]) |
      same4(cells[3][0], cells[3][1], cells[3][2], cells[3][3]) |
      same4(cells[0][0], cells[1][0], cells[2][0], cells[3][0]) |
      same4(cells[0][1], cells[1][1], cells[2][1], cells[3][1]) |
      same4(cells[0][2], cells[1][2], cells[2][2], cells[3][2]) |
      same4(cells[0][3], cells[1][3], cells[2][3], cells[3][3]) |
      same4(cells[0][0], cells[1][1], cells[2][2], cells[3][3]) |
      same4(cells[0][3], cells[1][2], cells[2][1], cells[3][0]);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.drop_valid) state_nxt = PLACE;
      PLACE:   state_nxt = col_full ? IDLE : CHECK;
      CHECK:   state_nxt = (line_win || (move_cnt == 5'd16)) ? OVER : IDLE;
      OVER:    state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
  end

  // Game state and registered outputs; status pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      board_q  <= '0;
      player_q <= 2'b01;
      winner_q <= 2'b00;
      col_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      h        <= '0;
      move_cnt <= '0;
    end else begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.drop_valid) col_q <= bus.column_decode;
        end
        PLACE: begin
          if (col_full) begin
            err_q <= 1'b1;
          end else begin
            board_q[{wr_cell, 1'b0} +: 2] <= player_q;
            h[col_q] <= h_sel + 3'd1;
            move_cnt <= move_cnt + 5'd1;
          end
        end
        CHECK: begin
          ok_q <= 1'b1;
          if (line_win)                 winner_q <= player_q;
          else if (move_cnt == 5'd16)   winner_q <= 2'b11;
          else                          player_q <= (player_q == 2'b01) ? 2'b10 : 2'b01;
        end
        OVER: begin
          if (bus.drop_valid) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.board          = board_q;
  assign bus.current_player = player_q;
  assign bus.winner         = winner_q;
  assign bus.drop_ok        = ok_q;
  assign bus.drop_err       = err_q;
  assign bus.busy           = (state == PLACE) || (state == CHECK);
  assign bus.game_over      = (state == OVER);

endmodule

// File: tb/tb_column_drop_engine.sv
// Self-checking bench for column_drop_engine. A reference game model fills
// a scoreboard queue as requests are issued; a monitor pops and compares on
// every drop_ok / drop_err pulse, including the cycle on which it appears.
module tb_column_drop_engine;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_seen;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  column_drop_if bus();

  column_drop_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_err;
    int          due;
    logic [31:0] board;
    logic [1:0]  player;
    logic [1:0]  winner;
    logic        over;
  } exp_t;

  exp_t sb[$];

  // Reference game model.
  logic [1:0] mb [4][4];
  int         mh [4];
  logic [1:0] mp;
  logic [1:0] mw;
  bit         mover;
  int         mcnt;

  function automatic bit line4(input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] c, input logic [1:0] d);
    return (a != 2'b00) && (a == b) && (b == c) && (c == d);
  endfunction

  function automatic bit model_win();
    bit w = 0;
    for (int i = 0; i < 4; i++) begin
      if (line4(mb[i][0], mb[i][1], mb[i][2], mb[i][3])) w = 1;
      if (line4(mb[0][i], mb[1][i], mb[2][i], mb[3][i])) w = 1;
    end
    if (line4(mb[0][0], mb[1][1], mb[2][2], mb[3][3])) w = 1;
    if (line4(mb[3][0], mb[2][1], mb[1][2], mb[0][3])) w = 1;
    return w;
  endfunction

  function automatic logic [31:0] model_board();
    logic [31:0] b = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[(r*4+c)*2 +: 2] = mb[r][c];
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mb[r][c] = 2'b00;
    for (int c = 0; c < 4; c++) mh[c] = 0;
    mp = 2'b01; mw = 2'b00; mover = 0; mcnt = 0;
  endtask

  // Called at a negedge just before the sampling edge; due is the cyc value
  // seen at the negedge on which the pulse must be visible.
  task automatic model_drop(input int col, output exp_t e);
    e.is_err = 1;
    e.due    = cyc + 1;
    if (!mover) begin
      if (mh[col] == 4) begin
        e.due = cyc + 2;
      end else begin
        mb[mh[col]][col] = mp;
        mh[col]++;
        mcnt++;
        e.is_err = 0;
        e.due    = cyc + 3;
        if (model_win()) begin
          mw = mp; mover = 1;
        end else if (mcnt == 16) begin
          mw = 2'b11; mover = 1;
        end else begin
          mp = (mp == 2'b01) ? 2'b10 : 2'b01;
        end
      end
    end
    e.board  = model_board();
    e.player = mp;
    e.winner = mw;
    e.over   = mover;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (bus.drop_ok || bus.drop_err)) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse ok=%b err=%b cyc=%0d required no pulse",
                 bus.drop_ok, bus.drop_err, cyc);
      end else begin
        e = sb.pop_front();
        if ({bus.drop_ok, bus.drop_err} !== {~e.is_err, e.is_err} || cyc != e.due ||
            bus.board !== e.board || bus.current_player !== e.player ||
            bus.winner !== e.winner || bus.game_over !== e.over) begin
          n_fail++;
          $display("FAIL scoreboard got ok=%b err=%b cyc=%0d board=%h player=%b winner=%b over=%b required ok=%b err=%b cyc=%0d board=%h player=%b winner=%b over=%b",
                   bus.drop_ok, bus.drop_err, cyc, bus.board, bus.current_player, bus.winner,
                   bus.game_over, ~e.is_err, e.is_err, e.due, e.board, e.player, e.winner, e.over);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.drop_valid = 1'b0;
    bus.column_decode = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    model_reset();
  endtask

  // Issue one request and wait (bounded) for the scoreboard to drain.
  task automatic drop(input int col);
    exp_t e;
    model_drop(col, e);
    sb.push_back(e);
    bus.drop_valid = 1'b1;
    bus.column_decode = col[1:0];
    @(negedge clk);
    bus.drop_valid = 1'b0;
    bus.column_decode = ~col[1:0];
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      busy_seen += int'(bus.busy);
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drop_timeout col=%0d pending=%0d required 0", col, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    logic [40:0] got;
    do_reset();
    got = {bus.board, bus.current_player, bus.winner, bus.drop_ok, bus.drop_err,
           bus.busy, bus.game_over};
    n_checks++;
    if (got !== {32'h0, 2'b01, 2'b00, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_values got=%h required=%h", got, {32'h0, 2'b01, 2'b00, 4'b0000});
    end
  endtask

  task automatic test_first_drop();
    do_reset();
    drop(2);
    n_checks++;
    if (bus.board[5:4] !== 2'b01 || bus.current_player !== 2'b10) begin
      n_fail++;
      $display("FAIL first_drop cell=%b player=%b required cell=01 player=10",
               bus.board[5:4], bus.current_player);
    end
    n_checks++;
    if (busy_seen != 2) begin
      n_fail++;
      $display("FAIL first_drop_busy cycles=%0d required 2", busy_seen);
    end
  endtask

  task automatic test_column_fill();
    do_reset();
    for (int i = 0; i < 5; i++) drop(0);
    n_checks++;
    if (bus.board !== 32'h02010201 || bus.current_player !== 2'b01) begin
      n_fail++;
      $display("FAIL column_fill board=%h player=%b required board=02010201 player=01",
               bus.board, bus.current_player);
    end
  endtask

  task automatic test_row_win();
    int seq[7] = '{0, 0, 1, 1, 2, 2, 3};
    do_reset();
    foreach (seq[i]) drop(seq[i]);
    n_checks++;
    if (bus.winner !== 2'b01 || bus.game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL row_win winner=%b over=%b required winner=01 over=1",
               bus.winner, bus.game_over);
    end
    drop(0);
    drop(3);
  endtask

  task automatic test_vertical_win();
    int seq[7] = '{1, 2, 1, 2, 1, 2, 1};
    do_reset();
    foreach (seq[i]) drop(seq[i]);
    n_checks++;
    if (bus.winner !== 2'b01 || bus.game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL vertical_win winner=%b over=%b required winner=01 over=1",
               bus.winner, bus.game_over);
    end
  endtask

  task automatic test_diag_win();
    int seq[10] = '{1, 0, 2, 1, 3, 2, 3, 2, 3, 3};
    do_reset();
    foreach (seq[i]) drop(seq[i]);
    n_checks++;
    if (bus.winner !== 2'b10 || bus.game_over !== 1'b1 || bus.current_player !== 2'b10) begin
      n_fail++;
      $display("FAIL diag_win winner=%b over=%b player=%b required winner=10 over=1 player=10",
               bus.winner, bus.game_over, bus.current_player);
    end
  endtask

  task automatic test_draw();
    int seq[16] = '{0, 2, 1, 3, 2, 0, 3, 1, 0, 2, 1, 3, 2, 0, 3, 1};
    do_reset();
    foreach (seq[i]) drop(seq[i]);
    n_checks++;
    if (bus.winner !== 2'b11 || bus.game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL draw winner=%b over=%b required winner=11 over=1",
               bus.winner, bus.game_over);
    end
  endtask

  task automatic test_reset_mid_check();
    logic [40:0] got;
    int seq[6] = '{0, 0, 1, 1, 2, 2};
    do_reset();
    foreach (seq[i]) drop(seq[i]);
    bus.drop_valid = 1'b1;
    bus.column_decode = 2'd3;
    @(negedge clk);
    bus.drop_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.board[7:6] !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_check_setup busy=%b cell=%b required busy=1 cell=01",
               bus.busy, bus.board[7:6]);
    end
    reset = 1'b1;
    @(negedge clk);
    got = {bus.board, bus.current_player, bus.winner, bus.drop_ok, bus.drop_err,
           bus.busy, bus.game_over};
    n_checks++;
    if (got !== {32'h0, 2'b01, 2'b00, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_mid_check got=%h required=%h", got, {32'h0, 2'b01, 2'b00, 4'b0000});
    end
    reset = 1'b0;
    sb.delete();
    model_reset();
    drop(3);
    n_checks++;
    if (bus.board !== 32'h00000040 || bus.current_player !== 2'b10) begin
      n_fail++;
      $display("FAIL after_reset_drop board=%h player=%b required board=00000040 player=10",
               bus.board, bus.current_player);
    end
  endtask

  task automatic test_ignore_busy();
    exp_t e;
    do_reset();
    model_drop(1, e);
    sb.push_back(e);
    bus.drop_valid = 1'b1;
    bus.column_decode = 2'd1;
    @(negedge clk);
    bus.column_decode = 2'd3;
    @(negedge clk);
    bus.column_decode = 2'd0;
    @(negedge clk);
    bus.drop_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (sb.size() != 0 || bus.board !== 32'h00000004 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_busy pending=%0d board=%h busy=%b required pending=0 board=00000004 busy=0",
               sb.size(), bus.board, bus.busy);
    end
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout time=%0t required finish earlier", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    bus.drop_valid = 1'b0;
    bus.column_decode = 2'b00;
    model_reset();
    test_reset();
    test_first_drop();
    test_column_fill();
    test_row_win();
    test_vertical_win();
    test_diag_win();
    test_draw();
    test_reset_mid_check();
    test_ignore_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
